// File: rtl/dmem_access_ctrl.sv
// M-stage load/store controller: drives a request/response data-memory bus,
// holds the pipeline through waitM, and handles lanes, extension and timeout.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        waitM,
  output logic [31:0] ReadDataM,
  output logic        misalignM,
  output logic        bus_errM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic          we_q;

  logic          legal, start, err_set, timeout_hit;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d, shifted, ld_ext;

  always_comb begin
    legal = 1'b0;
    case (funct3M)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~ALUResultM[0];
      3'b010:  legal = (ALUResultM[1:0] == 2'b00);
      3'b100:  legal = ~MemWriteM;
      3'b101:  legal = ~MemWriteM & ~ALUResultM[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
      end
    endcase
  end

  always_comb begin
    shifted = bus_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // A store granted on the final allowed cycle still completes; a load cannot
  // finish in that cycle, so timeout wins over its grant.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (MemReqM && legal) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus_gnt && we_q) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end else if (bus_gnt) begin
          state_nxt = RSP;
        end
      end
      RSP: begin
        if (bus_rvalid) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      ReadDataM <= '0;
      bus_errM  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus_errM <= err_set;
      if (start) begin
        cnt     <= '0;
        addr_q  <= ALUResultM;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        f3_q    <= funct3M;
        we_q    <= MemWriteM;
      end else if (state == REQ || state == RSP) begin
        cnt <= cnt + 1'b1;
      end
      if (err_set) begin
        ReadDataM <= '0;
      end else if (state == RSP && bus_rvalid) begin
        ReadDataM <= ld_ext;
      end
    end
  end

  assign waitM     = (state == IDLE && MemReqM && legal) || state == REQ || state == RSP;
  assign misalignM = (state == IDLE) && MemReqM && !legal;
  assign bus_req   = (state == REQ);
  assign bus_we    = (state == REQ) && we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: lane/extension cases, stalls,
// misalignment, reset mid-transaction and timeout on a short-timeout instance.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReqM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  funct3M = '0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic        waitM, misalignM, bus_errM, bus_req, bus_we;
  logic [31:0] ReadDataM, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        t_req = 1'b0, t_gnt = 1'b0, t_rvalid = 1'b0;
  logic [31:0] t_rdata = '0;
  logic        t_wait, t_mis, t_err, t_bus_req, t_we;
  logic [31:0] t_rd, t_addr, t_wdata;
  logic [3:0]  t_be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .waitM(waitM), .ReadDataM(ReadDataM), .misalignM(misalignM), .bus_errM(bus_errM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  dmem_access_ctrl #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .MemReqM(t_req), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .waitM(t_wait), .ReadDataM(t_rd), .misalignM(t_mis), .bus_errM(t_err),
    .bus_req(t_bus_req), .bus_we(t_we), .bus_addr(t_addr), .bus_be(t_be),
    .bus_wdata(t_wdata), .bus_gnt(t_gnt), .bus_rvalid(t_rvalid), .bus_rdata(t_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int gnt_wait,
                      input logic [31:0] rdata, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd, input int ewait);
    int waits;
    waits = 0;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = we; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    #1;
    check({tag, "_misal"}, misalignM, 32'd0);
    waits += int'(waitM);
    for (int i = 0; i <= gnt_wait; i++) begin
      @(negedge clk);
      MemReqM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0;
      bus_gnt = (i == gnt_wait);
      #1;
      waits += int'(waitM);
      check({tag, "_req"}, bus_req, 32'd1);
      check({tag, "_we"}, bus_we, {31'd0, we});
      check({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
      check({tag, "_be"}, bus_be, ebe);
      check({tag, "_wdata"}, bus_wdata, ewd);
    end
    if (!we) begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata;
      #1;
      waits += int'(waitM);
      check({tag, "_rsp_req"}, bus_req, 32'd0);
    end
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #1;
    waits += int'(waitM);
    check({tag, "_done_req"}, bus_req, 32'd0);
    check({tag, "_done_err"}, bus_errM, 32'd0);
    if (!we) check({tag, "_rdata"}, ReadDataM, erd);
    check({tag, "_waits"}, waits, ewait);
  endtask

  task automatic illegal(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a);
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = we; funct3M = f3; ALUResultM = a; WriteDataM = 32'hCAFEF00D;
    #1;
    check({tag, "_misal"}, misalignM, 32'd1);
    check({tag, "_wait"}, waitM, 32'd0);
    check({tag, "_req"}, bus_req, 32'd0);
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    check({tag, "_req_next"}, bus_req, 32'd0);
    check({tag, "_misal_clr"}, misalignM, 32'd0);
  endtask

  initial begin
    #1;
    check("rst_req", bus_req, 32'd0);
    check("rst_wait", waitM, 32'd0);
    check("rst_rd", ReadDataM, 32'd0);
    check("rst_be", bus_be, 32'd0);
    check("rst_err", bus_errM, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xact("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF, 3);
    xact("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF0000, 4'b1000, 32'h0, 32'hFFFFFF80, 3);
    xact("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0000, 4'b1000, 32'h0, 32'h00000080, 3);
    xact("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80FF0000, 4'b1100, 32'h0, 32'h000080FF, 3);
    xact("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF0000, 4'b1100, 32'h0, 32'hFFFF80FF, 4);
    xact("sb201",  1'b1, 3'b000, 32'h201, 32'h12345678, 3, 32'h0, 4'b0010, 32'h78787878, 32'h0, 5);
    xact("sh202",  1'b1, 3'b001, 32'h202, 32'hAAAA1234, 0, 32'h0, 4'b1100, 32'h12341234, 32'h0, 2);
    xact("sw204",  1'b1, 3'b010, 32'h204, 32'h0BADF00D, 0, 32'h0, 4'hF, 32'h0BADF00D, 32'h0, 2);

    illegal("lw102", 1'b0, 3'b010, 32'h102);
    illegal("sh203", 1'b1, 3'b001, 32'h203);
    illegal("ld011", 1'b0, 3'b011, 32'h100);
    illegal("sbu",   1'b1, 3'b100, 32'h100);

    // Reset asserted while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h300;
    @(negedge clk);
    MemReqM = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; rst_n = 1'b0;
    #1;
    check("mrst_req", bus_req, 32'd0);
    check("mrst_wait", waitM, 32'd0);
    check("mrst_rd", ReadDataM, 32'd0);
    check("mrst_addr", bus_addr, 32'd0);
    check("mrst_be", bus_be, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    #1;
    check("late_wait", waitM, 32'd0);
    check("late_req", bus_req, 32'd0);
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #1;
    check("late_rd", ReadDataM, 32'd0);
    check("late_err", bus_errM, 32'd0);
    xact("lw_post", 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h13579BDF, 4'hF, 32'h0, 32'h13579BDF, 3);

    // Short-timeout instance: load that is never granted.
    @(negedge clk);
    t_req = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h100;
    #1;
    check("to_wait_idle", t_wait, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      t_req = 1'b0;
      #1;
      check("to_req", t_bus_req, 32'd1);
      check("to_wait", t_wait, 32'd1);
    end
    @(negedge clk);
    #1;
    check("to_done_err", t_err, 32'd1);
    check("to_done_rd", t_rd, 32'd0);
    check("to_done_req", t_bus_req, 32'd0);
    check("to_done_wait", t_wait, 32'd0);
    @(negedge clk);
    #1;
    check("to_idle_err", t_err, 32'd0);
    check("to_idle_req", t_bus_req, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage load/store controller for the 5-stage pipeline. It turns the M-stage load/store into a multi-cycle request/response transaction on the data-memory bus and generates `waitM`, which holds F/D/E/M in the hazard unit until the access completes. It handles byte/half/word lanes, load extension, misalignment detection and a bus timeout.

## Interface
- `TIMEOUT`, 255: max cycles spent in REQ+RSP before abort (≥2).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `MemReqM`  in  1  M-stage instruction is a load or store.
- `MemWriteM`  in  1  1 = store, 0 = load.
- `funct3M`  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data (low bits significant).
- `waitM`  out  1  to hazard unit; 1 = M stage busy, pipeline must hold.
- `ReadDataM`  out  32  extended load result; valid in DONE.
- `misalignM`  out  1  access illegal/misaligned, no bus activity.
- `bus_errM`  out  1  access aborted by timeout.
- `bus_req`  out  1  request valid.
- `bus_we`  out  1  write request.
- `bus_addr`  out  32  word address (`ALUResultM[31:2]`, 2'b00).
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data word.

## Operation
- States: IDLE, REQ, RSP, DONE.
- Legality: lh/lhu/sh need `addr[0]==0`; lw/sw need `addr[1:0]==0`; funct3 011/110/111 (loads) or ≥011 (stores) illegal.
- IDLE: `MemReqM` & legal → latch addr/we/be/wdata/funct3/`addr[1:0]`, go REQ; `waitM=1` combinationally this cycle. `MemReqM` & illegal → `misalignM=1`, `waitM=0`, stay IDLE, no request. No `MemReqM` → stay IDLE.
- REQ: `bus_req=1`, bus fields from latches, stable until `bus_gnt`. On `bus_gnt`: store → DONE; load → RSP.
- RSP: `bus_req=0`; on `bus_rvalid` capture extended data → DONE. `bus_rvalid` never accepted in the `bus_gnt` cycle.
- DONE: `waitM=0`, `ReadDataM` holds result; unconditionally → IDLE. Pipeline advances at end of DONE; the next access starts in the following IDLE cycle.
- `waitM` = (IDLE & `MemReqM` & legal) | REQ | RSP.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `4'b0011<<{addr[1],1'b0}`; word `4'b1111`.
- Store data: byte `{4{wd[7:0]}}`, half `{2{wd[15:0]}}`, word `wd`.
- Load: `shifted = bus_rdata >> (8*addr[1:0])`; lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw unchanged.
- Timeout: counter cleared on IDLE→REQ, increments in REQ/RSP; reaching `TIMEOUT` → DONE with `bus_errM=1`, `ReadDataM=0`, `bus_req` dropped.
- `bus_rvalid`/`bus_gnt` outside the expected state are ignored.

## Timing
- Reset (async, `rst_n=0`): state IDLE, counter 0, `bus_req/bus_we=0`, `bus_addr/bus_wdata=0`, `bus_be=0`, `ReadDataM=0`, `misalignM/bus_errM=0`; `waitM` then depends only on IDLE decode. Reset mid-transaction drops `bus_req` immediately; late responses ignored.
- Min store: IDLE, REQ(gnt), DONE = 3 cycles in M, `waitM` high 2 cycles.
- Min load: IDLE, REQ(gnt), RSP(rvalid), DONE = 4 cycles, `waitM` high 3.
- `ReadDataM`, `bus_errM` registered, valid only in DONE; `misalignM` combinational, IDLE only.
- Each extra cycle without `bus_gnt`/`bus_rvalid` adds one `waitM` cycle.

## Test plan
- lw addr 0x100, gnt in first REQ cycle, rvalid next with 0xDEADBEEF → `ReadDataM=0xDEADBEEF` in DONE, `waitM` high exactly 3 cycles, `bus_be=4'hF`.
- lb addr 0x103, rdata 0x80FF_0000 → `ReadDataM=0xFFFFFF80`; lbu same → `0x00000080`; lhu addr 0x102 → `0x000080FF`.
- sb addr 0x201, wd 0x12345678 → `bus_be=4'b0010`, `bus_wdata=0x78787878`, `bus_we=1`; gnt held off 3 cycles → request fields stable, `waitM` high 5 cycles.
- lw addr 0x102 → `misalignM=1`, `waitM=0`, `bus_req` never asserted; sh addr 0x203 likewise.
- `TIMEOUT=4`, load with no gnt → DONE after 4 REQ cycles, `bus_errM=1`, `ReadDataM=0`, `bus_req` low in DONE.
- Assert `rst_n=0` in RSP, then rvalid after release → outputs at reset values immediately, state IDLE, late rvalid ignored.
